// File: rtl/fft_radix2_param.sv
// In-place radix-2 DIT FFT: streams N samples in, one butterfly per cycle, streams N bins out in natural order.
// Optional per-stage 1/2 scaling is enabled by defining FFT_STAGE_SCALE_EN.
module fft_radix2_param #(
  parameter int NBITS = 16,
  parameter int LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_push,
  input  logic signed [NBITS-1:0] in_real,
  input  logic signed [NBITS-1:0] in_imag,
  output logic                    in_stall,
  output logic                    out_push_F,
  output logic signed [NBITS-1:0] out_real_F,
  output logic signed [NBITS-1:0] out_imag_F,
  input  logic                    out_stall
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int SW   = $clog2(LOG2N);
  localparam int MW   = 2 * NBITS;
  localparam int PW   = 2 * NBITS + 2;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_COMP = 2'd1;
  localparam logic [1:0] ST_UNLD = 2'd2;

  localparam logic signed [PW-1:0] SAT_HI = {{(PW-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [LOG2N-2:0] tidx_t;

  function automatic addr_t bitrev(input addr_t a);
    addr_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Accumulator is in Q(NBITS-1) product scale; drop back to sample scale, truncating.
  function automatic logic signed [NBITS-1:0] scale_sat(input logic signed [PW-1:0] acc);
    logic signed [PW-1:0] sh;
    sh = acc >>> (NBITS-1);
`ifdef FFT_STAGE_SCALE_EN
    sh = sh >>> 1;
`endif
    if (sh > SAT_HI) return SAT_HI[NBITS-1:0];
    if (sh < SAT_LO) return SAT_LO[NBITS-1:0];
    return sh[NBITS-1:0];
  endfunction

  function automatic logic signed [NBITS-1:0] tw_val(input int k, input logic sin_part);
    real ang, v;
    int  q;
    ang = 6.283185307179586 * real'(k) / real'(N);
    v   = sin_part ? -$sin(ang) : $cos(ang);
    v   = v * real'(1 << (NBITS-1));
    q   = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    if (q > (1 << (NBITS-1)) - 1) q = (1 << (NBITS-1)) - 1;
    return q[NBITS-1:0];
  endfunction

  logic [MW-1:0]           mem [N];
  logic signed [NBITS-1:0] tw_re [HALF];
  logic signed [NBITS-1:0] tw_im [HALF];

  for (genvar k = 0; k < HALF; k++) begin : g_tw
    assign tw_re[k] = tw_val(k, 1'b0);
    assign tw_im[k] = tw_val(k, 1'b1);
  end

  logic [1:0]    state;
  addr_t         in_cnt, b_cnt, out_k;
  logic [SW-1:0] s_cnt;

  assign in_stall = (state != ST_LOAD);

  // Stage p0: butterfly addressing, memory read and arithmetic
  logic  bubble_p0;
  addr_t hmask_p0, top_p0, bot_p0, rd_a, rd_b;
  tidx_t tw_idx_p0;

  assign bubble_p0 = (b_cnt == addr_t'(HALF));

  always_comb begin
    hmask_p0  = (addr_t'(1) << s_cnt) - addr_t'(1);
    top_p0    = ((b_cnt & ~hmask_p0) << 1) | (b_cnt & hmask_p0);
    bot_p0    = top_p0 | (hmask_p0 + addr_t'(1));
    tw_idx_p0 = tidx_t'((b_cnt & hmask_p0) << (SW'(LOG2N-1) - s_cnt));
    rd_a      = top_p0;
    rd_b      = bot_p0;
    if (state == ST_UNLD)                rd_a = out_k + addr_t'(1);
    else if (state == ST_COMP && bubble_p0) rd_a = '0;
  end

  logic signed [NBITS-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0, w_re_p0, w_im_p0;
  logic signed [MW-1:0]    p_rr_p0, p_ii_p0, p_ri_p0, p_ir_p0;
  logic signed [PW-1:0]    bw_re_p0, bw_im_p0, a_re_ext_p0, a_im_ext_p0;

  assign a_re_p0 = mem[rd_a][MW-1:NBITS];
  assign a_im_p0 = mem[rd_a][NBITS-1:0];
  assign b_re_p0 = mem[rd_b][MW-1:NBITS];
  assign b_im_p0 = mem[rd_b][NBITS-1:0];
  assign w_re_p0 = tw_re[tw_idx_p0];
  assign w_im_p0 = tw_im[tw_idx_p0];

  assign p_rr_p0 = MW'(b_re_p0) * MW'(w_re_p0);
  assign p_ii_p0 = MW'(b_im_p0) * MW'(w_im_p0);
  assign p_ri_p0 = MW'(b_re_p0) * MW'(w_im_p0);
  assign p_ir_p0 = MW'(b_im_p0) * MW'(w_re_p0);

  assign bw_re_p0    = PW'(p_rr_p0) - PW'(p_ii_p0);
  assign bw_im_p0    = PW'(p_ri_p0) + PW'(p_ir_p0);
  assign a_re_ext_p0 = PW'(a_re_p0) <<< (NBITS-1);
  assign a_im_ext_p0 = PW'(a_im_p0) <<< (NBITS-1);

  // Stage p1: registered butterfly results, written back on the next edge
  logic signed [NBITS-1:0] x_re_p1, x_im_p1, y_re_p1, y_im_p1;
  addr_t                   top_p1, bot_p1;
  logic                    vld_p1;

  always_ff @(posedge clk) begin
    x_re_p1 <= scale_sat(a_re_ext_p0 + bw_re_p0);
    x_im_p1 <= scale_sat(a_im_ext_p0 + bw_im_p0);
    y_re_p1 <= scale_sat(a_re_ext_p0 - bw_re_p0);
    y_im_p1 <= scale_sat(a_im_ext_p0 - bw_im_p0);
    top_p1  <= top_p0;
    bot_p1  <= bot_p0;
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD && in_push) mem[bitrev(in_cnt)] <= {in_real, in_imag};
    if (vld_p1) begin
      mem[top_p1] <= {x_re_p1, x_im_p1};
      mem[bot_p1] <= {y_re_p1, y_im_p1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_LOAD;
      in_cnt     <= '0;
      b_cnt      <= '0;
      s_cnt      <= '0;
      out_k      <= '0;
      vld_p1     <= 1'b0;
      out_push_F <= 1'b0;
      out_real_F <= '0;
      out_imag_F <= '0;
    end else begin
      vld_p1 <= (state == ST_COMP) && !bubble_p0;
      case (state)
        ST_LOAD: begin
          if (in_push) begin
            in_cnt <= in_cnt + addr_t'(1);
            if (in_cnt == addr_t'(N-1)) begin
              state <= ST_COMP;
              b_cnt <= '0;
              s_cnt <= '0;
            end
          end
        end
        ST_COMP: begin
          // The bubble slot lets the stage's last write land before the next stage reads.
          if (bubble_p0) begin
            b_cnt <= '0;
            if (s_cnt == SW'(LOG2N-1)) begin
              state      <= ST_UNLD;
              out_k      <= '0;
              out_push_F <= 1'b1;
              out_real_F <= a_re_p0;
              out_imag_F <= a_im_p0;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end else begin
            b_cnt <= b_cnt + addr_t'(1);
          end
        end
        ST_UNLD: begin
          if (!out_stall) begin
            if (out_k == addr_t'(N-1)) begin
              out_push_F <= 1'b0;
              state      <= ST_LOAD;
            end else begin
              out_k      <= out_k + addr_t'(1);
              out_real_F <= a_re_p0;
              out_imag_F <= a_im_p0;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
